imem_load_controller: RTL and testbench

- Boot-time sequencer for the byte-addressed instruction memory of the single-cycle core.
- Holds the core in reset and streams a program image, one byte per handshake, into instruction memory at ascending byte addresses from 0.
- Verifies an 8-bit additive checksum, then releases the core. From that point it hands the memory address port to the core's PC.
- Sits between the host/UART byte source, the instruction memory and the core's PC/reset.

---
 rtl/imem_ctrl_pkg.sv | 18 +
 rtl/imem_load_controller.sv | 129 ++++++++++++
 tb/tb_imem_load_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t     : FSM encoding, also exported on the debug state port
//   MEM_BYTES_D : default instruction memory size in bytes
//   CSUM_W      : width of the additive image checksum
package imem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam int unsigned MEM_BYTES_D = 1024;
    localparam int unsigned CSUM_W      = 8;

endpackage

// File: rtl/imem_load_controller.sv
// Boot-time sequencer: holds the core in reset, streams a program image
// byte by byte into instruction memory from address 0, verifies a mod-256
// additive checksum and then releases the core, handing the memory address
// port over to the core PC.
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   load_start           one-cycle load request (load_len/load_csum sampled)
//   load_len, load_csum  image length in bytes, expected mod-256 byte sum
//   s_valid/s_data       byte source; s_ready high while in LOAD
//   pc_addr              core PC, drives imem_addr while running
//   imem_addr/we/wdata   instruction memory write port (registered write)
//   core_hold            1 = core held in reset
//   load_done/load_err   verified-and-running / load failed
//   state                FSM state for debug
module imem_load_controller
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_D,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LEN_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [LEN_W-1:0]  load_len,
    input  logic [CSUM_W-1:0] load_csum,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [7:0]        imem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [2:0]        state
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MEM_BYTES);

    state_t              r_state;
    state_t              w_next_state;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_count;
    logic [LEN_W-1:0]    r_waddr;
    logic [CSUM_W-1:0]   r_csum;
    logic [CSUM_W-1:0]   r_sum;
    logic                r_we;
    logic [7:0]          r_wdata;
    logic                w_accept;
    logic                w_last;
    logic                w_start_load;

    assign s_ready    = (r_state == ST_LOAD);
    assign w_accept   = s_valid & s_ready;
    assign w_last     = (r_count == r_len - 1'b1);

    assign imem_addr  = (r_state == ST_RUN) ? pc_addr : ADDR_W'(r_waddr);
    assign imem_we    = r_we;
    assign imem_wdata = r_wdata;
    assign core_hold  = (r_state != ST_RUN);
    assign load_done  = (r_state == ST_RUN);
    assign load_err   = (r_state == ST_ERROR);
    assign state      = r_state;

    always_comb begin
        w_next_state = r_state;
        w_start_load = 1'b0;
        case (r_state)
            // RUN and ERROR accept a new request exactly like IDLE does.
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (load_start) begin
                    if (load_len == '0) begin
                        w_next_state = ST_RUN;
                    end else if (load_len > MAX_LEN) begin
                        w_next_state = ST_ERROR;
                    end else begin
                        w_next_state = ST_LOAD;
                        w_start_load = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (w_accept && w_last) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_next_state = (r_sum == r_csum) ? ST_RUN : ST_ERROR;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_count <= '0;
            r_waddr <= '0;
            r_csum  <= '0;
            r_sum   <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            // Write port lags acceptance by one cycle; the address is the
            // pre-increment byte count.
            r_we    <= w_accept;
            if (w_accept) begin
                r_wdata <= s_data;
                r_waddr <= r_count;
                r_count <= r_count + 1'b1;
                r_sum   <= r_sum + s_data;
            end
            if (w_start_load) begin
                r_len   <= load_len;
                r_csum  <= load_csum;
                r_count <= '0;
                r_sum   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_load_controller.sv
// Self-checking bench for imem_load_controller: a table of directed loads,
// hand-written full-length and reset-mid-load sequences, and randomized
// loads whose outcome comes from a plain byte-sum reference.
module tb_imem_load_controller;

    localparam int unsigned MEM = 1024;
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_CHECK = 3'd2,
                           S_RUN = 3'd3, S_ERR = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [15:0] load_len;
    logic [7:0]  load_csum;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [31:0] pc_addr;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [7:0]  imem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;
    logic [2:0]  state;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] img [MEM];

    always #5 clk = ~clk;

    imem_load_controller #(.MEM_BYTES(MEM), .ADDR_W(32), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .load_csum(load_csum), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .pc_addr(pc_addr), .imem_addr(imem_addr),
        .imem_we(imem_we), .imem_wdata(imem_wdata), .core_hold(core_hold),
        .load_done(load_done), .load_err(load_err), .state(state)
    );

    typedef struct {
        int unsigned len;
        logic [7:0]  csum;
        logic [31:0] bytes;
        int unsigned gap;
        bit          noise;
        logic [2:0]  exp_final;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference outcome: plain mod-256 sum of the first len image bytes.
    function automatic logic [7:0] ref_sum(input int unsigned len);
        int unsigned s = 0;
        for (int unsigned i = 0; i < len; i++) s += img[i];
        return s[7:0];
    endfunction

    task automatic chk_status(input string tag, input logic [2:0] exp);
        chk({tag, "_state"}, state, exp);
        chk({tag, "_hold"}, core_hold, exp != S_RUN);
        chk({tag, "_done"}, load_done, exp == S_RUN);
        chk({tag, "_err"}, load_err, exp == S_ERR);
        chk({tag, "_we"}, imem_we, 1'b0);
        if (exp == S_RUN) begin
            pc_addr = $urandom;
            #1;
            chk({tag, "_pc_addr"}, imem_addr, pc_addr);
        end
    endtask

    task automatic do_load(input int unsigned len, input logic [7:0] csum,
                           input int unsigned gap, input bit rand_gap,
                           input bit noise, input logic [2:0] exp_final);
        int unsigned g;
        load_start = 1'b1;
        load_len   = 16'(len);
        load_csum  = csum;
        s_valid    = 1'b0;
        tick();
        load_start = 1'b0;
        if (len == 0 || len > MEM) begin
            chk_status("start", exp_final);
            return;
        end
        chk("start_state", state, S_LOAD);
        chk("start_hold", core_hold, 1'b1);
        chk("start_we", imem_we, 1'b0);
        for (int unsigned i = 0; i < len; i++) begin
            g = rand_gap ? $urandom_range(0, gap) : gap;
            for (int unsigned k = 0; k < g; k++) begin
                s_valid    = 1'b0;
                s_data     = 8'($urandom);
                load_start = noise ? 1'($urandom) : 1'b0;
                load_len   = '0;
                tick();
                chk("gap_we", imem_we, 1'b0);
                chk("gap_ready", s_ready, 1'b1);
                chk("gap_state", state, S_LOAD);
            end
            s_valid    = 1'b1;
            s_data     = img[i];
            load_start = noise ? 1'($urandom) : 1'b0;
            load_len   = '0;
            tick();
            chk("wr_we", imem_we, 1'b1);
            chk("wr_addr", imem_addr, i);
            chk("wr_data", imem_wdata, img[i]);
            chk("wr_state", state, (i == len - 1) ? S_CHECK : S_LOAD);
            chk("wr_ready", s_ready, i != len - 1);
        end
        // CHECK cycle: stray bytes and requests must be ignored here.
        s_valid    = noise;
        s_data     = 8'($urandom);
        load_start = noise;
        load_len   = '0;
        tick();
        load_start = 1'b0;
        s_valid    = 1'b0;
        chk_status("final", exp_final);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{4,    8'h13, 32'h0000_0013, 0, 1'b0, S_RUN};
        vecs[1] = '{2,    8'h01, 32'h0000_02FF, 3, 1'b0, S_RUN};
        vecs[2] = '{4,    8'h14, 32'h0000_0013, 0, 1'b0, S_ERR};
        vecs[3] = '{4,    8'h13, 32'h0000_0013, 1, 1'b1, S_RUN};
        vecs[4] = '{4,    8'h0A, 32'h0403_0201, 0, 1'b1, S_RUN};
        vecs[5] = '{0,    8'h00, 32'h0,         0, 1'b0, S_RUN};
        vecs[6] = '{MEM+1,8'h00, 32'h0,         0, 1'b0, S_ERR};
        vecs[7] = '{0,    8'h55, 32'h0,         0, 1'b0, S_RUN};
        vecs[8] = '{1,    8'hAB, 32'h0000_00AB, 0, 1'b0, S_RUN};

        rst = 1'b0; load_start = 1'b0; load_len = '0; load_csum = '0;
        s_valid = 1'b0; s_data = '0; pc_addr = 32'h0000_0008;
        tick();
        tick();
        chk("rst_state", state, S_IDLE);
        chk("rst_hold", core_hold, 1'b1);
        chk("rst_ready", s_ready, 1'b0);
        chk("rst_we", imem_we, 1'b0);
        chk("rst_wdata", imem_wdata, 8'h00);
        chk("rst_done", load_done, 1'b0);
        chk("rst_err", load_err, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        rst = 1'b1;
        tick();
        chk("idle_state", state, S_IDLE);

        foreach (vecs[v]) begin
            for (int unsigned b = 0; b < 4; b++) img[b] = vecs[v].bytes[8*b +: 8];
            do_load(vecs[v].len, vecs[v].csum, vecs[v].gap, 1'b0,
                    vecs[v].noise, vecs[v].exp_final);
        end

        // Full-size image: last write lands at MEM-1.
        for (int unsigned i = 0; i < MEM; i++) img[i] = 8'($urandom);
        do_load(MEM, ref_sum(MEM), 0, 1'b0, 1'b0, S_RUN);

        // Reset in the middle of a load.
        for (int unsigned i = 0; i < 8; i++) img[i] = 8'($urandom);
        load_start = 1'b1; load_len = 16'd8; load_csum = ref_sum(8);
        tick();
        load_start = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = img[i];
            tick();
        end
        chk("mid_we_before", imem_we, 1'b1);
        rst = 1'b0; s_data = img[3];
        tick();
        rst = 1'b1;
        chk("mid_rst_state", state, S_IDLE);
        chk("mid_rst_ready", s_ready, 1'b0);
        chk("mid_rst_hold", core_hold, 1'b1);
        chk("mid_rst_we", imem_we, 1'b0);
        for (int unsigned i = 4; i < 7; i++) begin
            s_data = img[i];
            tick();
            chk("post_rst_we", imem_we, 1'b0);
            chk("post_rst_state", state, S_IDLE);
        end
        s_valid = 1'b0;

        // Randomized loads against the byte-sum reference.
        for (int n = 0; n < 30; n++) begin
            int unsigned r   = $urandom_range(0, 9);
            int unsigned len;
            logic [7:0]  cs;
            logic [2:0]  ex;
            if (r == 0) begin
                len = 0; cs = 8'($urandom); ex = S_RUN;
            end else if (r == 1) begin
                len = MEM + 1 + $urandom_range(0, 5000); cs = 8'($urandom); ex = S_ERR;
            end else begin
                len = $urandom_range(1, 24);
                for (int unsigned i = 0; i < len; i++) img[i] = 8'($urandom);
                cs = ref_sum(len);
                if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
                ex = (cs == ref_sum(len)) ? S_RUN : S_ERR;
            end
            do_load(len, cs, 2, 1'b1, 1'($urandom), ex);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
